// File: rtl/pi_vel_ctrl_param_if.sv
// Signal bundle between the register/encoder side and the PI velocity controller.
// The master drives setpoint, position, gains and mode bits; the slave returns velocity and duty command.
interface pi_vel_ctrl_param_if #(
   parameter int POS_W  = 32,
   parameter int GAIN_W = 16,
   parameter int OUT_W  = 16
);
   logic                     enable;
   logic                     int_clr;
   logic signed [POS_W-1:0]  desired_vel;
   logic signed [POS_W-1:0]  actual_pos;
   logic        [GAIN_W-1:0] Kp_axi;
   logic        [GAIN_W-1:0] Ki_axi;
   logic signed [POS_W-1:0]  actual_vel;
   logic                     vel_valid;
   logic signed [OUT_W-1:0]  control_signal;
   logic                     ctrl_valid;
   logic                     sat;

   modport master (
      output enable, int_clr, desired_vel, actual_pos, Kp_axi, Ki_axi,
      input  actual_vel, vel_valid, control_signal, ctrl_valid, sat
   );

   modport slave (
      input  enable, int_clr, desired_vel, actual_pos, Kp_axi, Ki_axi,
      output actual_vel, vel_valid, control_signal, ctrl_valid, sat
   );
endinterface

// File: rtl/pi_vel_ctrl_param.sv
// PI velocity controller: windowed encoder velocity plus a 4-stage PI law with anti-windup and clamp.
// Latency tick->ctrl_valid 4 cycles, tick->vel_valid 1 cycle; no backpressure, outputs hold between pulses.
module pi_vel_ctrl_param #(
   parameter int CLK_DIV    = 5000,
   parameter int VEL_WINDOW = 10,
   parameter int POS_W      = 32,
   parameter int GAIN_W     = 16,
   parameter int INT_W      = 48,
   parameter int FRAC_SHIFT = 32,
   parameter int OUT_W      = 16,
   parameter int OUT_LIMIT  = 4000,
   parameter int DEADBAND   = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   pi_vel_ctrl_param_if.slave bus
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
   localparam int ERR_W = POS_W + 1;
   localparam int ACC_W = INT_W + 1;
   localparam int P_W   = ERR_W + GAIN_W + 1;
   localparam int I_W   = INT_W + GAIN_W + 1;
   localparam int SUM_W = ((P_W > I_W) ? P_W : I_W) + 1;

   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(VEL_WINDOW - 1);
   localparam logic signed [ACC_W-1:0] INT_MAX  = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] INT_MIN  = {2'b11, {(INT_W-1){1'b0}}};
   localparam logic signed [SUM_W-1:0] LIM_POS  = SUM_W'(OUT_LIMIT);
   localparam logic signed [SUM_W-1:0] LIM_NEG  = -LIM_POS;
   localparam logic signed [ERR_W-1:0] DB_POS   = ERR_W'(DEADBAND);
   localparam logic signed [ERR_W-1:0] DB_NEG   = -DB_POS;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    tick;
   logic [WIN_W-1:0]        win_q, win_d;
   logic signed [POS_W-1:0] prev_pos_q, prev_pos_d;
   logic signed [POS_W-1:0] vsum_q, vsum_d;
   logic signed [POS_W-1:0] actual_vel_q, actual_vel_d;
   logic                    vel_valid_q, vel_valid_d;
   logic signed [POS_W-1:0] delta;

   logic                    s1_vld_q, s1_vld_d;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic [GAIN_W-1:0]       kp_q, kp_d;
   logic [GAIN_W-1:0]       ki_q, ki_d;
   logic                    en1_q, en1_d;
   logic                    clr1_q, clr1_d;

   logic                    s2_vld_q, s2_vld_d;
   logic signed [INT_W-1:0] integral_q, integral_d;
   logic signed [ACC_W-1:0] acc;
   logic                    in_db, wind_hold;
   logic                    err_pos, err_neg, cs_pos, cs_neg;

   logic                    s3_vld_q, s3_vld_d;
   logic signed [P_W-1:0]   p_q, p_d;
   logic signed [I_W-1:0]   i_q, i_d;

   logic signed [SUM_W-1:0] pi_sum, shifted;
   logic signed [OUT_W-1:0] control_signal_q, control_signal_d;
   logic                    sat_q, sat_d;
   logic                    ctrl_valid_q, ctrl_valid_d;

   assign tick = (cnt_q == CNT_LAST);

   // Velocity: modular delta makes encoder wrap look like a small step.
   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
      delta        = bus.actual_pos - prev_pos_q;
      prev_pos_d   = prev_pos_q;
      vsum_d       = vsum_q;
      win_d        = win_q;
      actual_vel_d = actual_vel_q;
      vel_valid_d  = 1'b0;
      if (tick) begin
         prev_pos_d = bus.actual_pos;
         if (win_q == WIN_LAST) begin
            actual_vel_d = vsum_q + delta;
            vsum_d       = '0;
            win_d        = '0;
            vel_valid_d  = 1'b1;
         end else begin
            vsum_d = vsum_q + delta;
            win_d  = win_q + WIN_W'(1);
         end
      end
   end

   // Stage 1 samples the pre-update velocity and latches gains/mode once per tick.
   always_comb begin
      s1_vld_d = tick;
      err_d    = err_q;
      kp_d     = kp_q;
      ki_d     = ki_q;
      en1_d    = en1_q;
      clr1_d   = clr1_q;
      if (tick) begin
         err_d  = ERR_W'(bus.desired_vel) - ERR_W'(actual_vel_q);
         kp_d   = bus.Kp_axi;
         ki_d   = bus.Ki_axi;
         en1_d  = bus.enable;
         clr1_d = bus.int_clr;
      end
   end

   // Stage 2: integrator; wind-up is only blocked in the direction pushing further into the clamp.
   always_comb begin
      s2_vld_d   = s1_vld_q;
      integral_d = integral_q;
      acc        = ACC_W'(integral_q) + ACC_W'(err_q);
      in_db      = (err_q < DB_POS) && (err_q > DB_NEG);
      err_neg    = err_q[ERR_W-1];
      err_pos    = !err_q[ERR_W-1] && (err_q != '0);
      cs_neg     = control_signal_q[OUT_W-1];
      cs_pos     = !control_signal_q[OUT_W-1] && (control_signal_q != '0);
      wind_hold  = sat_q && ((err_pos && cs_pos) || (err_neg && cs_neg));
      if (s1_vld_q) begin
         if (clr1_q || !en1_q) begin
            integral_d = '0;
         end else if (in_db || wind_hold) begin
            integral_d = integral_q;
         end else if (acc > INT_MAX) begin
            integral_d = INT_MAX[INT_W-1:0];
         end else if (acc < INT_MIN) begin
            integral_d = INT_MIN[INT_W-1:0];
         end else begin
            integral_d = acc[INT_W-1:0];
         end
      end
   end

   // Stage 3: full-precision products; gains are zero-extended before the signed multiply.
   always_comb begin
      s3_vld_d = s2_vld_q;
      p_d      = p_q;
      i_d      = i_q;
      if (s2_vld_q) begin
         p_d = P_W'($signed({1'b0, kp_q})) * P_W'(err_q);
         i_d = I_W'($signed({1'b0, ki_q})) * I_W'(integral_q);
      end
   end

   // Stage 4: clamp at full width so no truncated value can slip past the limit.
   always_comb begin
      pi_sum           = SUM_W'(p_q) + SUM_W'(i_q);
      shifted          = pi_sum >>> FRAC_SHIFT;
      ctrl_valid_d     = s3_vld_q;
      control_signal_d = control_signal_q;
      sat_d            = sat_q;
      if (s3_vld_q) begin
         if (!en1_q) begin
            control_signal_d = '0;
            sat_d            = 1'b0;
         end else if (shifted > LIM_POS) begin
            control_signal_d = OUT_W'(LIM_POS);
            sat_d            = 1'b1;
         end else if (shifted < LIM_NEG) begin
            control_signal_d = OUT_W'(LIM_NEG);
            sat_d            = 1'b1;
         end else begin
            control_signal_d = OUT_W'(shifted);
            sat_d            = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q            <= '0;
         win_q            <= '0;
         prev_pos_q       <= '0;
         vsum_q           <= '0;
         actual_vel_q     <= '0;
         vel_valid_q      <= 1'b0;
         s1_vld_q         <= 1'b0;
         err_q            <= '0;
         kp_q             <= '0;
         ki_q             <= '0;
         en1_q            <= 1'b0;
         clr1_q           <= 1'b0;
         s2_vld_q         <= 1'b0;
         integral_q       <= '0;
         s3_vld_q         <= 1'b0;
         p_q              <= '0;
         i_q              <= '0;
         control_signal_q <= '0;
         sat_q            <= 1'b0;
         ctrl_valid_q     <= 1'b0;
      end else begin
         cnt_q            <= cnt_d;
         win_q            <= win_d;
         prev_pos_q       <= prev_pos_d;
         vsum_q           <= vsum_d;
         actual_vel_q     <= actual_vel_d;
         vel_valid_q      <= vel_valid_d;
         s1_vld_q         <= s1_vld_d;
         err_q            <= err_d;
         kp_q             <= kp_d;
         ki_q             <= ki_d;
         en1_q            <= en1_d;
         clr1_q           <= clr1_d;
         s2_vld_q         <= s2_vld_d;
         integral_q       <= integral_d;
         s3_vld_q         <= s3_vld_d;
         p_q              <= p_d;
         i_q              <= i_d;
         control_signal_q <= control_signal_d;
         sat_q            <= sat_d;
         ctrl_valid_q     <= ctrl_valid_d;
      end
   end

   assign bus.actual_vel     = actual_vel_q;
   assign bus.vel_valid      = vel_valid_q;
   assign bus.control_signal = control_signal_q;
   assign bus.ctrl_valid     = ctrl_valid_q;
   assign bus.sat            = sat_q;

endmodule
